// File: rtl/swipe_tracker.sv
// Saber swipe tracker: turns per-frame centroid samples into a start/current
// segment and converts the detector's combinational verdict into one-shot hit events.
module swipe_tracker #(
    parameter int unsigned STILL_THRESH    = 4,
    parameter int unsigned MIN_LEN         = 64,
    parameter int unsigned MAX_FRAMES      = 15,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pos_valid_in,
    input  logic [10:0] pos_x_in,
    input  logic [9:0]  pos_y_in,
    input  logic        is_intersecting_in,
    output logic [10:0] saber_start_x,
    output logic [9:0]  saber_start_y,
    output logic [10:0] saber_current_x,
    output logic [9:0]  saber_current_y,
    output logic        swipe_active_out,
    output logic        swipe_done_out,
    output logic        hit_out
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned DW = 12;
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SWIPING  = 2'd1,
        EVAL     = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [XW-1:0]  prev_x, prev_x_nxt;
    logic [YW-1:0]  prev_y, prev_y_nxt;
    logic           have_prev, have_prev_nxt;
    logic [FW-1:0]  frame_cnt, frame_cnt_nxt;
    logic [CW-1:0]  cool_cnt, cool_cnt_nxt;
    logic [XW-1:0]  start_x_nxt, current_x_nxt;
    logic [YW-1:0]  start_y_nxt, current_y_nxt;
    logic           active_nxt, done_nxt, hit_nxt;

    // Frame delta against the previous sample and segment length
    logic [XW-1:0]  dx, len_x;
    logic [YW-1:0]  dy, len_y;
    logic [DW-1:0]  delta, len;
    logic           still, scored;
    logic [FW-1:0]  frame_inc;
    logic [CW-1:0]  cool_inc;

    assign dx    = (pos_x_in >= prev_x) ? pos_x_in - prev_x : prev_x - pos_x_in;
    assign dy    = (pos_y_in >= prev_y) ? pos_y_in - prev_y : prev_y - pos_y_in;
    assign delta = DW'(dx) + DW'(dy);
    assign still = delta < DW'(STILL_THRESH);

    assign len_x = (saber_current_x >= saber_start_x) ? saber_current_x - saber_start_x
                                                      : saber_start_x - saber_current_x;
    assign len_y = (saber_current_y >= saber_start_y) ? saber_current_y - saber_start_y
                                                      : saber_start_y - saber_current_y;
    assign len    = DW'(len_x) + DW'(len_y);
    assign scored = is_intersecting_in && (len >= DW'(MIN_LEN));

    assign frame_inc = frame_cnt + FW'(1);
    assign cool_inc  = cool_cnt + CW'(1);

    // Next-state and next-register logic
    always_comb begin
        state_nxt     = state;
        prev_x_nxt    = prev_x;
        prev_y_nxt    = prev_y;
        have_prev_nxt = have_prev;
        frame_cnt_nxt = frame_cnt;
        cool_cnt_nxt  = cool_cnt;
        start_x_nxt   = saber_start_x;
        start_y_nxt   = saber_start_y;
        current_x_nxt = saber_current_x;
        current_y_nxt = saber_current_y;
        done_nxt      = 1'b0;
        hit_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (pos_valid_in) begin
                    prev_x_nxt    = pos_x_in;
                    prev_y_nxt    = pos_y_in;
                    have_prev_nxt = 1'b1;
                    if (have_prev) begin
                        current_x_nxt = pos_x_in;
                        current_y_nxt = pos_y_in;
                        if (still) begin
                            start_x_nxt = pos_x_in;
                            start_y_nxt = pos_y_in;
                        end else begin
                            start_x_nxt   = prev_x;
                            start_y_nxt   = prev_y;
                            frame_cnt_nxt = FW'(1);
                            state_nxt     = SWIPING;
                        end
                    end
                end
            end
            SWIPING: begin
                if (pos_valid_in) begin
                    prev_x_nxt    = pos_x_in;
                    prev_y_nxt    = pos_y_in;
                    current_x_nxt = pos_x_in;
                    current_y_nxt = pos_y_in;
                    frame_cnt_nxt = frame_inc;
                    if (still || (frame_inc == FW'(MAX_FRAMES))) begin
                        state_nxt = EVAL;
                    end
                end
            end
            EVAL: begin
                // Samples arriving here are dropped so the segment stays stable
                done_nxt = 1'b1;
                hit_nxt  = scored;
                if (scored) begin
                    cool_cnt_nxt = CW'(0);
                    state_nxt    = COOLDOWN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            COOLDOWN: begin
                if (pos_valid_in) begin
                    prev_x_nxt    = pos_x_in;
                    prev_y_nxt    = pos_y_in;
                    start_x_nxt   = pos_x_in;
                    start_y_nxt   = pos_y_in;
                    current_x_nxt = pos_x_in;
                    current_y_nxt = pos_y_in;
                    cool_cnt_nxt  = cool_inc;
                    if (cool_inc == CW'(COOLDOWN_FRAMES)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        active_nxt = (state_nxt == SWIPING);
    end

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            prev_x           <= '0;
            prev_y           <= '0;
            have_prev        <= 1'b0;
            frame_cnt        <= '0;
            cool_cnt         <= '0;
            saber_start_x    <= '0;
            saber_start_y    <= '0;
            saber_current_x  <= '0;
            saber_current_y  <= '0;
            swipe_active_out <= 1'b0;
            swipe_done_out   <= 1'b0;
            hit_out          <= 1'b0;
        end else begin
            state            <= state_nxt;
            prev_x           <= prev_x_nxt;
            prev_y           <= prev_y_nxt;
            have_prev        <= have_prev_nxt;
            frame_cnt        <= frame_cnt_nxt;
            cool_cnt         <= cool_cnt_nxt;
            saber_start_x    <= start_x_nxt;
            saber_start_y    <= start_y_nxt;
            saber_current_x  <= current_x_nxt;
            saber_current_y  <= current_y_nxt;
            swipe_active_out <= active_nxt;
            swipe_done_out   <= done_nxt;
            hit_out          <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_swipe_tracker.sv
// Self-checking bench for swipe_tracker: directed scenarios plus random samples
// compared against a per-sample behavioural model of swipe/cooldown rules.
module tb_swipe_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        pos_valid_in;
    logic [10:0] pos_x_in;
    logic [9:0]  pos_y_in;
    logic        is_intersecting_in;
    logic [10:0] saber_start_x, saber_current_x;
    logic [9:0]  saber_start_y, saber_current_y;
    logic        swipe_active_out, swipe_done_out, hit_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (sample-level, not cycle-level)
    int m_px, m_py, m_sx, m_sy, m_cx, m_cy, m_frames, m_cool_seen;
    bit m_have, m_swiping, m_cooling;

    swipe_tracker dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .pos_valid_in       (pos_valid_in),
        .pos_x_in           (pos_x_in),
        .pos_y_in           (pos_y_in),
        .is_intersecting_in (is_intersecting_in),
        .saber_start_x      (saber_start_x),
        .saber_start_y      (saber_start_y),
        .saber_current_x    (saber_current_x),
        .saber_current_y    (saber_current_y),
        .swipe_active_out   (swipe_active_out),
        .swipe_done_out     (swipe_done_out),
        .hit_out            (hit_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_sx = 0; m_sy = 0; m_cx = 0; m_cy = 0;
        m_frames = 0; m_cool_seen = 0;
        m_have = 0; m_swiping = 0; m_cooling = 0;
    endtask

    // Apply one sample to the model; reports whether it ends a swipe and whether that scores
    task automatic model_step(input int x, input int y, input bit isect,
                              output bit ended, output bit hit);
        int d;
        ended = 0;
        hit   = 0;
        d = iabs(x - m_px) + iabs(y - m_py);
        if (m_cooling) begin
            m_px = x; m_py = y; m_sx = x; m_sy = y; m_cx = x; m_cy = y;
            m_cool_seen++;
            if (m_cool_seen == 30) m_cooling = 0;
        end else if (m_swiping) begin
            m_px = x; m_py = y; m_cx = x; m_cy = y;
            m_frames++;
            if (d < 4 || m_frames == 15) begin
                m_swiping = 0;
                ended = 1;
                hit = isect && (iabs(m_cx - m_sx) + iabs(m_cy - m_sy) >= 64);
                if (hit) begin
                    m_cooling = 1;
                    m_cool_seen = 0;
                end
            end
        end else if (!m_have) begin
            m_px = x; m_py = y; m_have = 1;
        end else if (d < 4) begin
            m_px = x; m_py = y; m_sx = x; m_sy = y; m_cx = x; m_cy = y;
        end else begin
            m_sx = m_px; m_sy = m_py; m_cx = x; m_cy = y;
            m_px = x; m_py = y;
            m_frames = 1;
            m_swiping = 1;
        end
    endtask

    task automatic check_seg(input string tag);
        chk({tag, ".start_x"}, 32'(saber_start_x), 32'(m_sx));
        chk({tag, ".start_y"}, 32'(saber_start_y), 32'(m_sy));
        chk({tag, ".cur_x"}, 32'(saber_current_x), 32'(m_cx));
        chk({tag, ".cur_y"}, 32'(saber_current_y), 32'(m_cy));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".start_x"}, 32'(saber_start_x), 0);
        chk({tag, ".start_y"}, 32'(saber_start_y), 0);
        chk({tag, ".cur_x"}, 32'(saber_current_x), 0);
        chk({tag, ".cur_y"}, 32'(saber_current_y), 0);
        chk({tag, ".active"}, 32'(swipe_active_out), 0);
        chk({tag, ".done"}, 32'(swipe_done_out), 0);
        chk({tag, ".hit"}, 32'(hit_out), 0);
    endtask

    // Entered and left at a negedge
    task automatic do_reset();
        rst_in = 1'b1;
        pos_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        check_zero("reset");
    endtask

    // One frame: pulse, then follow the EVAL cycle and the pulse cycle; optionally
    // inject a pulse during EVAL which must be ignored.
    task automatic do_sample(input string tag, input int x, input int y, input bit poke);
        bit ended, hit;
        model_step(x, y, is_intersecting_in, ended, hit);
        pos_valid_in = 1'b1;
        pos_x_in = 11'(x);
        pos_y_in = 10'(y);
        @(posedge clk_in);
        @(negedge clk_in);
        pos_valid_in = 1'b0;
        check_seg({tag, ".s1"});
        chk({tag, ".active"}, 32'(swipe_active_out), 32'(m_swiping));
        chk({tag, ".done_early"}, 32'(swipe_done_out), 0);
        chk({tag, ".hit_early"}, 32'(hit_out), 0);
        if (ended && poke) begin
            pos_valid_in = 1'b1;
            pos_x_in = 11'($urandom_range(0, 2047));
            pos_y_in = 10'($urandom_range(0, 1023));
        end
        @(posedge clk_in);
        @(negedge clk_in);
        pos_valid_in = 1'b0;
        chk({tag, ".done"}, 32'(swipe_done_out), 32'(ended));
        chk({tag, ".hit"}, 32'(hit_out), 32'(hit));
        check_seg({tag, ".s2"});
        @(posedge clk_in);
        @(negedge clk_in);
        chk({tag, ".done_after"}, 32'(swipe_done_out), 0);
        chk({tag, ".hit_after"}, 32'(hit_out), 0);
    endtask

    initial begin
        int x, y;
        rst_in = 1'b1;
        pos_valid_in = 1'b0;
        pos_x_in = '0;
        pos_y_in = '0;
        is_intersecting_in = 1'b0;
        @(negedge clk_in);

        // Still input keeps a degenerate segment
        do_reset();
        do_sample("still", 100, 100, 0);
        do_sample("still", 102, 101, 0);
        chk("still.start_x_abs", 32'(saber_start_x), 102);
        chk("still.cur_y_abs", 32'(saber_current_y), 101);

        // Scoring swipe, then cooldown against fast motion
        do_reset();
        is_intersecting_in = 1'b1;
        do_sample("score", 128, 128, 0);
        do_sample("score", 256, 128, 0);
        chk("score.active_rise", 32'(swipe_active_out), 1);
        do_sample("score", 384, 192, 0);
        do_sample("score", 385, 192, 0);
        chk("score.start_x_abs", 32'(saber_start_x), 128);
        chk("score.cur_x_abs", 32'(saber_current_x), 385);
        for (int i = 0; i < 32; i++) begin
            do_sample("cool", (i % 2 == 0) ? 900 : 500, 300 + i, 0);
        end

        // Short swipe with a dropped pulse during evaluation
        do_reset();
        do_sample("short", 200, 200, 0);
        do_sample("short", 210, 200, 0);
        do_sample("short", 220, 200, 0);
        do_sample("short", 220, 201, 1);
        do_sample("short", 221, 201, 0);

        // Timeout after the maximum number of frames
        do_reset();
        is_intersecting_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_sample("timeout", 50 + 10 * i, 300, 0);
        end

        // Reset mid-swipe emits nothing
        do_reset();
        do_sample("midrst", 100, 100, 0);
        do_sample("midrst", 200, 100, 0);
        do_sample("midrst", 300, 100, 0);
        pos_valid_in = 1'b1;
        pos_x_in = 11'd400;
        pos_y_in = 10'd100;
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        pos_valid_in = 1'b0;
        model_reset();
        check_zero("midrst.after");
        repeat (2) begin
            @(posedge clk_in);
            @(negedge clk_in);
            chk("midrst.no_done", 32'(swipe_done_out), 0);
        end

        // Random walk: mix of still steps and large jumps
        do_reset();
        x = 1000;
        y = 500;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x += int'($urandom_range(0, 1));
                y += int'($urandom_range(0, 1));
            end else begin
                x += int'($urandom_range(0, 160)) - 80;
                y += int'($urandom_range(0, 100)) - 50;
            end
            if (x < 0) x = 0;
            if (x > 2047) x = 2047;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            is_intersecting_in = ($urandom_range(0, 2) != 0);
            do_sample("rand", x, y, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
